// File: rtl/branch_pred_pkg.sv
// Shared types and constants for the branch predictor: counter encodings,
// the in-flight entry layout and the saturating counter update helper.
package branch_pred_pkg;

    localparam logic [1:0] SNT       = 2'b00;
    localparam logic [1:0] WNT       = 2'b01;
    localparam logic [1:0] WT        = 2'b10;
    localparam logic [1:0] ST        = 2'b11;
    localparam logic [1:0] CTR_RESET = WNT;

    // Wide enough for tables up to 256 entries; the top narrows it back.
    localparam int IDX_W_MAX = 8;

    typedef struct packed {
        logic [IDX_W_MAX-1:0] index;
        logic                 pred;
    } bp_entry_t;

    function automatic logic [1:0] ctr_update(input logic [1:0] ctr, input logic taken);
        logic [1:0] nxt;
        nxt = ctr;
        if (taken) begin
            if (ctr != ST) begin
                nxt = ctr + 2'd1;
            end else begin
                nxt = ST;
            end
        end else begin
            if (ctr != SNT) begin
                nxt = ctr - 2'd1;
            end else begin
                nxt = SNT;
            end
        end
        return nxt;
    endfunction

endpackage

// File: rtl/bp_inflight_fifo.sv
// In-flight branch FIFO: holds index and prediction of every predicted branch
// until execute resolves it; clear empties it in the same edge as any pop.
module bp_inflight_fifo
    import branch_pred_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      push,
    input  logic      pop,
    input  logic      clear,
    input  bp_entry_t push_entry,
    output bp_entry_t head_entry,
    output logic      full,
    output logic      empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    bp_entry_t        mem_r [DEPTH];
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full       = (count_r == CNT_W'(DEPTH));
    assign empty      = (count_r == {CNT_W{1'b0}});
    assign push_ok_s  = push & ~full;
    assign pop_ok_s   = pop & ~empty;
    assign head_entry = mem_r[rd_ptr_r];

    // Pointer and occupancy tracking; clear wins over push and pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_r <= {PTR_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else if (clear) begin
            rd_ptr_r <= {PTR_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            count_r <= count_r + CNT_W'(push_ok_s) - CNT_W'(pop_ok_s);
        end
    end

    // Entry storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '{index: {IDX_W_MAX{1'b0}}, pred: 1'b0};
            end
        end else if (push_ok_s && !clear) begin
            mem_r[wr_ptr_r] <= push_entry;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Bimodal branch predictor: a table of 2-bit saturating counters indexed by
// PC word bits, trained in order as execute resolves in-flight branches.
module branch_predictor
    import branch_pred_pkg::*;
#(
    parameter int BHT_ENTRIES = 16,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pred_valid,
    input  logic [31:0] pred_pc,
    output logic        pred_ready,
    output logic        pred_resp_valid,
    output logic        pred_taken,
    input  logic        resolve_valid,
    input  logic        resolve_taken,
    input  logic        flush,
    output logic        mispredict,
    output logic        resolve_err
);

    localparam int IDX_W = $clog2(BHT_ENTRIES);

    logic [1:0]       bht_r [BHT_ENTRIES];
    logic [IDX_W-1:0] lookup_idx_s;
    logic [IDX_W-1:0] head_idx_s;
    bp_entry_t        push_entry_s;
    bp_entry_t        head_entry_s;
    logic             full_s;
    logic             empty_s;
    logic             accept_s;
    logic             resolve_ok_s;
    logic             mispred_s;
    logic             clear_s;
    logic             push_s;
    logic             lookup_pred_s;
    logic             unused_pc_s;
    logic             pred_resp_valid_r;
    logic             pred_taken_r;
    logic             mispredict_r;
    logic             resolve_err_r;

    assign lookup_idx_s  = pred_pc[IDX_W+1:2];
    assign unused_pc_s   = ^{pred_pc[31:IDX_W+2], pred_pc[1:0]};
    assign lookup_pred_s = bht_r[lookup_idx_s][1];
    assign head_idx_s    = IDX_W'(head_entry_s.index);
    assign pred_ready    = ~full_s;

    // A mispredict squashes everything younger, including this cycle's push.
    always_comb begin
        accept_s           = pred_valid & pred_ready;
        resolve_ok_s       = resolve_valid & ~empty_s;
        mispred_s          = resolve_ok_s & (resolve_taken != head_entry_s.pred);
        clear_s            = flush | mispred_s;
        push_s             = accept_s & ~clear_s;
        push_entry_s.index = IDX_W_MAX'(lookup_idx_s);
        push_entry_s.pred  = lookup_pred_s;
    end

    bp_inflight_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_s),
        .pop       (resolve_ok_s),
        .clear     (clear_s),
        .push_entry(push_entry_s),
        .head_entry(head_entry_s),
        .full      (full_s),
        .empty     (empty_s)
    );

    // Counter table training; a same-cycle lookup sees the pre-update value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                bht_r[i] <= CTR_RESET;
            end
        end else if (resolve_ok_s) begin
            bht_r[head_idx_s] <= ctr_update(bht_r[head_idx_s], resolve_taken);
        end
    end

    // Registered response, mispredict pulse and sticky protocol error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pred_resp_valid_r <= 1'b0;
            pred_taken_r      <= 1'b0;
            mispredict_r      <= 1'b0;
            resolve_err_r     <= 1'b0;
        end else begin
            pred_resp_valid_r <= push_s;
            pred_taken_r      <= push_s ? lookup_pred_s : 1'b0;
            mispredict_r      <= mispred_s;
            resolve_err_r     <= resolve_err_r | (resolve_valid & empty_s);
        end
    end

    assign pred_resp_valid = pred_resp_valid_r;
    assign pred_taken      = pred_taken_r;
    assign mispredict      = mispredict_r;
    assign resolve_err     = resolve_err_r;

endmodule
